// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader_if
// Description : Field-bundle handshake and instruction-memory write port
//               bundle for the instruction encoder/loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic        addressing_mode;
    logic [2:0]  reg1;
    logic [2:0]  reg2;
    logic [2:0]  reg3;
    logic [4:0]  data_mem;
    logic [4:0]  instruction_mem;
    logic        im_we;
    logic [4:0]  im_addr;
    logic [15:0] im_wdata;
    logic        im_ack;

    // Harness side: supplies field bundles and acts as the memory.
    modport master (
        output in_valid, opcode, addressing_mode, reg1, reg2, reg3,
               data_mem, instruction_mem, im_ack,
        input  in_ready, im_we, im_addr, im_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, opcode, addressing_mode, reg1, reg2, reg3,
               data_mem, instruction_mem, im_ack,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Packs decoded instruction fields into 16-bit words, queues
//               them in a FIFO and writes them sequentially to instr memory.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int BASE_ADDR = 0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    instr_encoder_loader_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic [5:0]            count
);

    localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0]   c_DEPTH_L   = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = 1;
    localparam logic [c_PTR_W:0]   c_LVL_ONE   = 1;
    localparam logic [4:0]         c_BASE      = 5'(BASE_ADDR);
    localparam logic [4:0]         c_LAST_ADDR = 5'd31;
    localparam logic [3:0]         c_OP_HALT   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [15:0]         r_fifo [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_level;
    logic [4:0]          r_push_addr;
    logic [4:0]          r_wr_addr;
    logic [5:0]          r_count;
    logic                r_busy;
    logic                r_done;

    logic [15:0]         w_word;
    logic [c_PTR_W:0]    w_level_nxt;
    logic                w_full;
    logic                w_empty;
    logic                w_active;
    logic                w_ready;
    logic                w_we;
    logic                w_push;
    logic                w_pop;

    assign w_full   = (r_level == c_DEPTH_L);
    assign w_empty  = (r_level == '0);
    assign w_active = (r_state == S_LOAD) || (r_state == S_DRAIN);
    // A start pulse flushes the queue, so nothing is accepted or written on it.
    assign w_ready  = (r_state == S_LOAD) && !w_full && !start;
    assign w_we     = w_active && !w_empty && !start;
    assign w_push   = w_ready && bus.in_valid;
    assign w_pop    = w_we && bus.im_ack;

    always_comb begin
        w_word        = '0;
        w_word[15:12] = bus.opcode;
        w_word[11]    = bus.addressing_mode;
        case (bus.opcode)
            4'h0: begin
                w_word[10:8] = bus.reg1;
                if (bus.addressing_mode) w_word[7:3] = bus.data_mem;
                else                     w_word[7:5] = bus.reg2;
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hA: begin
                w_word[10:8] = bus.reg1;
                w_word[7:5]  = bus.reg2;
                if (bus.addressing_mode) w_word[4:0] = bus.data_mem;
                else                     w_word[4:2] = bus.reg3;
            end
            4'h5, 4'h6, 4'h9: begin
                if (bus.addressing_mode) w_word[10:6] = bus.data_mem;
                else                     w_word[10:8] = bus.reg1;
            end
            4'hB: begin
                w_word[10:8] = bus.reg1;
                w_word[7:3]  = bus.data_mem;
            end
            4'hC: begin
                w_word[10:6] = bus.instruction_mem;
                w_word[5:3]  = bus.reg1;
            end
            4'hD: w_word[10:6] = bus.instruction_mem;
            default: ;
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LVL_ONE;
            2'b01:   w_level_nxt = r_level - c_LVL_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_push_addr <= '0;
            r_wr_addr   <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (start) begin
            r_state     <= S_LOAD;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_push_addr <= c_BASE;
            r_wr_addr   <= c_BASE;
            r_count     <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + c_PTR_ONE;
                r_push_addr <= r_push_addr + 5'd1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                r_wr_addr <= r_wr_addr + 5'd1;
                r_count   <= r_count + 6'd1;
            end
            case (r_state)
                // Limit is tracked on accepted words so the address never wraps.
                S_LOAD: begin
                    if (w_push && (bus.opcode == c_OP_HALT || r_push_addr == c_LAST_ADDR))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.im_we    = w_we;
    assign bus.im_addr  = r_wr_addr;
    assign bus.im_wdata = w_we ? r_fifo[r_rd_ptr] : 16'h0000;
    assign busy         = r_busy;
    assign done         = r_done;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Scoreboard bench for instr_encoder_loader (BASE 0 and BASE 30).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    logic       busy0, done0, busy1, done1;
    logic [5:0] count0, count1;

    int  total = 0;
    int  bad   = 0;
    wr_t q0[$];
    wr_t q1[$];
    int  ea0, ea1;

    instr_encoder_loader_if bus0 ();
    instr_encoder_loader_if bus1 ();

    assign bus1.opcode          = bus0.opcode;
    assign bus1.addressing_mode = bus0.addressing_mode;
    assign bus1.reg1            = bus0.reg1;
    assign bus1.reg2            = bus0.reg2;
    assign bus1.reg3            = bus0.reg3;
    assign bus1.data_mem        = bus0.data_mem;
    assign bus1.instruction_mem = bus0.instruction_mem;

    instr_encoder_loader #(.DEPTH(4), .BASE_ADDR(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
        .busy(busy0), .done(done0), .count(count0)
    );

    instr_encoder_loader #(.DEPTH(4), .BASE_ADDR(30)) u_dut30 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
        .busy(busy1), .done(done1), .count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic am,
                                        input logic [2:0] r1, input logic [2:0] r2,
                                        input logic [2:0] r3, input logic [4:0] dm,
                                        input logic [4:0] im);
        logic [15:0] w;
        w = {op, am, 11'd0};
        case (op)
            4'h0:                                     w = w | (am ? {5'd0, r1, dm, 3'd0} : {5'd0, r1, r2, 5'd0});
            4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hA: w = w | (am ? {5'd0, r1, r2, dm} : {5'd0, r1, r2, r3, 2'd0});
            4'h5, 4'h6, 4'h9:                         w = w | (am ? {5'd0, dm, 6'd0} : {5'd0, r1, 8'd0});
            4'hB:                                     w = w | {5'd0, r1, dm, 3'd0};
            4'hC:                                     w = w | {5'd0, im, r1, 3'd0};
            4'hD:                                     w = w | {5'd0, im, 6'd0};
            default: ;
        endcase
        return w;
    endfunction

    // Completed writes are checked against the scoreboard front.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus0.im_we && bus0.im_ack) begin
            chk("sb0_pending", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("wr0_addr", 32'(bus0.im_addr), 32'(e.a));
                chk("wr0_data", 32'(bus0.im_wdata), 32'(e.d));
            end
        end
        if (rst_n && bus1.im_we && bus1.im_ack) begin
            chk("sb1_pending", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("wr1_addr", 32'(bus1.im_addr), 32'(e.a));
                chk("wr1_data", 32'(bus1.im_wdata), 32'(e.d));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int which);
        if (which == 0) begin start0 = 1'b1; q0.delete(); ea0 = 0;  end
        else            begin start1 = 1'b1; q1.delete(); ea1 = 30; end
        tick(1);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send(input int which, input logic [3:0] op, input logic am,
                        input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3,
                        input logic [4:0] dm, input logic [4:0] im,
                        input bit exp_acc, input int budget);
        bit   acc;
        logic rdy;
        bus0.opcode = op; bus0.addressing_mode = am;
        bus0.reg1 = r1; bus0.reg2 = r2; bus0.reg3 = r3;
        bus0.data_mem = dm; bus0.instruction_mem = im;
        if (which == 0) bus0.in_valid = 1'b1; else bus1.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            rdy = (which == 0) ? bus0.in_ready : bus1.in_ready;
            if (rdy) begin
                acc = 1'b1;
                if (which == 0) begin q0.push_back(wr_t'{a: 5'(ea0), d: enc(op, am, r1, r2, r3, dm, im)}); ea0++; end
                else            begin q1.push_back(wr_t'{a: 5'(ea1), d: enc(op, am, r1, r2, r3, dm, im)}); ea1++; end
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        chk("accept", 32'(acc), 32'(exp_acc));
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && !bus0.im_we) break;
        end
        tick(1);
        chk("drain_empty", 32'(q0.size()), 0);
    endtask

    task automatic wait_done(input int which, input int budget);
        logic d;
        d = 1'b0;
        for (int i = 0; i < budget && !d; i++) begin
            @(negedge clk);
            d = (which == 0) ? done0 : done1;
        end
        tick(1);
        chk("done_seen", 32'(d), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus0.in_ready), 0);
        chk({tag, "_im_we"},    32'(bus0.im_we),    0);
        chk({tag, "_im_addr"},  32'(bus0.im_addr),  0);
        chk({tag, "_im_wdata"}, 32'(bus0.im_wdata), 0);
        chk({tag, "_busy"},     32'(busy0),         0);
        chk({tag, "_done"},     32'(done0),         0);
        chk({tag, "_count"},    32'(count0),        0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bp_ops [6];
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        bus0.im_ack = 1'b0;   bus1.im_ack = 1'b0;
        bus0.opcode = '0; bus0.addressing_mode = 1'b0;
        bus0.reg1 = '0; bus0.reg2 = '0; bus0.reg3 = '0;
        bus0.data_mem = '0; bus0.instruction_mem = '0;
        ea0 = 0; ea1 = 30;
        tick(2);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Encoding, field placement and HALT termination.
        bus0.im_ack = 1'b1;
        do_start(0);
        send(0, 4'h1, 1'b0, 3'd3, 3'd5, 3'd6, 5'd0, 5'd0, 1'b1, 10);
        wait_drain(20);
        chk("add_count", 32'(count0), 1);
        send(0, 4'hC, 1'b0, 3'd2, 3'd0, 3'd0, 5'd0,  5'd9, 1'b1, 10);
        send(0, 4'hB, 1'b1, 3'd7, 3'd0, 3'd0, 5'd31, 5'd0, 1'b1, 10);
        send(0, 4'hF, 1'b0, 3'd0, 3'd0, 3'd0, 5'd0,  5'd0, 1'b1, 10);
        chk("halt_ready", 32'(bus0.in_ready), 0);
        chk("halt_busy",  32'(busy0), 1);
        wait_done(0, 30);
        chk("halt_done",  32'(done0),  1);
        chk("halt_idle",  32'(busy0),  0);
        chk("halt_count", 32'(count0), 4);
        chk("halt_sb",    32'(q0.size()), 0);

        // Backpressure: memory stalls while six bundles are offered.
        bp_ops = '{4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'hA};
        bus0.im_ack = 1'b0;
        do_start(0);
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(0, bp_ops[k], 1'(k % 2), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                         3'($urandom_range(7, 0)), 5'($urandom_range(31, 0)), 5'd0, 1'b1, 40);
            end
            begin
                logic [4:0]  ha;
                logic [15:0] hd;
                bit          held;
                held = 1'b0; ha = '0; hd = '0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (bus0.im_we) begin
                        if (!held) begin
                            ha = bus0.im_addr; hd = bus0.im_wdata; held = 1'b1;
                        end else begin
                            chk("stall_addr", 32'(bus0.im_addr),  32'(ha));
                            chk("stall_data", 32'(bus0.im_wdata), 32'(hd));
                        end
                    end
                end
                chk("stall_we",      32'(held), 1);
                chk("stall_accepts", 32'(ea0), 4);
                chk("stall_ready",   32'(bus0.in_ready), 0);
                @(posedge clk);
                #1;
                bus0.im_ack = 1'b1;
            end
        join
        wait_drain(40);
        chk("bp_count", 32'(count0), 6);

        // Abort: a start with two words queued discards them.
        bus0.im_ack = 1'b0;
        do_start(0);
        send(0, 4'h1, 1'b0, 3'd1, 3'd2, 3'd3, 5'd0, 5'd0, 1'b1, 10);
        send(0, 4'h2, 1'b1, 3'd4, 3'd5, 3'd0, 5'd17, 5'd0, 1'b1, 10);
        chk("abort_pre_we", 32'(bus0.im_we), 1);
        do_start(0);
        chk("abort_count", 32'(count0), 0);
        chk("abort_we",    32'(bus0.im_we), 0);
        chk("abort_addr",  32'(bus0.im_addr), 0);
        bus0.im_ack = 1'b1;
        send(0, 4'h0, 1'b1, 3'd6, 3'd0, 3'd0, 5'd21, 5'd0, 1'b1, 10);
        wait_drain(20);
        chk("abort_count1", 32'(count0), 1);

        // Address limit with BASE_ADDR=30: only two words fit.
        bus1.im_ack = 1'b1;
        do_start(1);
        send(1, 4'h1, 1'b0, 3'd1, 3'd1, 3'd1, 5'd0, 5'd0, 1'b1, 10);
        send(1, 4'h8, 1'b1, 3'd2, 3'd3, 3'd0, 5'd9, 5'd0, 1'b1, 10);
        send(1, 4'h5, 1'b0, 3'd4, 3'd0, 3'd0, 5'd0, 5'd0, 1'b0, 8);
        wait_done(1, 30);
        chk("lim_done",  32'(done1),  1);
        chk("lim_busy",  32'(busy1),  0);
        chk("lim_count", 32'(count1), 2);
        chk("lim_sb",    32'(q1.size()), 0);

        // Reset in the middle of an outstanding write.
        bus0.im_ack = 1'b0;
        do_start(0);
        send(0, 4'hD, 1'b0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd13, 1'b1, 10);
        chk("rst_pre_we", 32'(bus0.im_we), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk_reset_outputs("midrst");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder. Accepts decoded instruction fields over a valid/ready handshake and packs them into 16-bit instruction words.
- Buffers the words in a small FIFO, then writes them sequentially into instruction memory through a write/ack port.
- Used by the bring-up/test harness to load programs into the 8-bit processor's 32-entry instruction memory.
- A load session ends on a HALT instruction or when memory is exhausted.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2).
- BASE_ADDR, 0, first instruction-memory address written after start (0..31).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new load session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle.
- opcode  input  4  instruction opcode.
- addressing_mode  input  1  addressing mode bit.
- reg1  input  3  register field 1.
- reg2  input  3  register field 2.
- reg3  input  3  register field 3.
- data_mem  input  5  data-memory address field.
- instruction_mem  input  5  instruction-memory address field.
- im_we  output  1  instruction-memory write request.
- im_addr  output  5  write address.
- im_wdata  output  16  write data.
- im_ack  input  1  memory accepted the current write.
- busy  output  1  session active (LOAD or DRAIN).
- done  output  1  session complete, sticky until start.
- count  output  6  words written this session.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; FIFO empty.
  - in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, count=0.
- Encoding (combinational on the input fields; written into the FIFO on accept). Common rules:
  - [15:12]=opcode; [11]=addressing_mode for every opcode.
  - Any bit not listed below is 0.
- Per-opcode field placement:
  - MOVE(0): am=0 → [10:8]=reg1, [7:5]=reg2. am=1 → [10:8]=reg1, [7:3]=data_mem.
  - ADD/SUB/MUL/DIV/AND/OR/XOR (1,2,3,4,7,8,A): am=0 → [10:8]=reg1, [7:5]=reg2, [4:2]=reg3. am=1 → [10:8]=reg1, [7:5]=reg2, [4:0]=data_mem.
  - INC/DEC/NOT (5,6,9): am=0 → [10:8]=reg1. am=1 → [10:6]=data_mem.
  - LOAD(B): [10:8]=reg1, [7:3]=data_mem.
  - STORE(C): [10:6]=instruction_mem, [5:3]=reg1.
  - JUMP(D): [10:6]=instruction_mem.
  - BRANCH(E), HALT(F): no fields; [10:0]=0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: in_ready=0. start → LOAD.
  - LOAD: in_ready = FIFO not full. Accept (push) when in_valid && in_ready.
    - Accepted opcode is HALT → DRAIN.
    - Accepted word targets address 31 → DRAIN. Addresses never wrap.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is outstanding → DONE.
  - DONE: done=1, in_ready=0. start → LOAD.
- Entering LOAD (from any state, via start):
  - Flush the FIFO; im_we=0.
  - Next write address = BASE_ADDR; count=0; done=0.
  - A start during LOAD or DRAIN aborts the session; pending words are discarded and never written.
- Write port:
  - im_we=1 whenever the FIFO is non-empty in LOAD or DRAIN.
  - im_addr and im_wdata present the FIFO head and hold stable while im_we=1 && im_ack=0.
  - On a cycle with im_we && im_ack: pop the FIFO, increment the address, increment count.
  - im_ack while im_we=0 is ignored.
- Latency: a bundle accepted at edge N can appear on im_we/im_wdata from cycle N+1 (registered FIFO).
- Full/empty:
  - No push when the FIFO is full, even if a pop occurs in the same cycle; in_ready derives from the registered full flag.
  - Push and pop in the same cycle, FIFO not full → occupancy unchanged, order preserved.
- Address-limit accounting uses accepted words, so at most (32−BASE_ADDR) words are accepted per session.
- busy=1 in LOAD and DRAIN only.
- Reset mid-write drops im_we immediately; the memory must tolerate an abandoned request.

Test Plan:
- Encoding: start, then ADD am=0 r1=3 r2=5 r3=6 with im_ack tied high → im_wdata=0x13B8 at im_addr=0, count=1.
- Field placement: STORE instruction_mem=9 reg1=2 → 0x C250. LOAD am=1 reg1=7 data_mem=31 → 0xBFF8. Written at consecutive addresses.
- HALT termination: three instructions then HALT (0xF000). After HALT is accepted, in_ready=0. Four writes occur at addresses 0–3, then done=1, busy=0, count=4.
- Backpressure: hold im_ack=0 for 10 cycles while feeding 6 bundles with DEPTH=4:
  - in_ready falls after 4 accepts.
  - im_addr/im_wdata stay stable during the stall.
  - Releasing im_ack drains all 6 words in order.
- Address limit: BASE_ADDR=30, feed 3 non-HALT bundles → only 2 accepted. Writes at 30 and 31; then done=1, count=2.
- Abort and reset: start mid-session with 2 words queued → queue discarded, next write at BASE_ADDR, count=0. Asserting rst_n=0 mid-write → all outputs return to reset values asynchronously.
